// File: rtl/ddr3_wr_arbiter.sv
// Round-robin burst arbiter from N camera write FIFOs onto the DDR3 user write port.
// Keeps a wrapping per-channel frame pointer with frame-start realignment.
module ddr3_wr_arbiter #(
  parameter int CH_NUM      = 4,
  parameter int DATA_W      = 128,
  parameter int CNT_W       = 11,
  parameter int ADDR_W      = 28,
  parameter int BURST_LEN   = 64,
  parameter int FRAME_BEATS = 38400,
  parameter int CH_STRIDE   = 65536
) (
  input  logic                        clk_100,
  input  logic                        rst,
  input  logic [CH_NUM*CNT_W-1:0]     wfifo_rcount,
  input  logic [CH_NUM*DATA_W-1:0]    wfifo_dout,
  input  logic [CH_NUM-1:0]           frame_start,
  input  logic                        wr_ready,
  output logic [CH_NUM-1:0]           wfifo_rden,
  output logic                        wr_en,
  output logic [DATA_W-1:0]           wr_data,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [$clog2(CH_NUM)-1:0]   grant_ch,
  output logic                        burst_active,
  output logic                        burst_done
);

  localparam int GW = $clog2(CH_NUM);
  localparam int PW = $clog2(FRAME_BEATS);
  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t          state_reg, state_next;
  logic [GW-1:0]   grant_reg, grant_next;
  logic [GW-1:0]   last_grant_reg, last_grant_next;
  logic [BW-1:0]   beat_cnt_reg, beat_cnt_next;
  logic [PW-1:0]   ptr_reg [CH_NUM];
  logic [CH_NUM-1:0] pend_reg;

  logic [CH_NUM-1:0] req;
  logic [ADDR_W-1:0] ch_addr [CH_NUM];
  logic [GW-1:0]     rr_pick;
  logic [GW-1:0]     rr_idx;
  logic              rr_found;

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(gi * CH_STRIDE);
    assign req[gi]     = wfifo_rcount[gi*CNT_W +: CNT_W] >= CNT_W'(BURST_LEN);
    assign ch_addr[gi] = BASE + ADDR_W'(ptr_reg[gi]);
  end

  // First requester after the last granted channel, wrapping around.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    rr_idx   = '0;
    for (int k = 1; k <= CH_NUM; k++) begin
      rr_idx = GW'((int'(last_grant_reg) + k) % CH_NUM);
      if (!rr_found && req[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    beat_cnt_next   = beat_cnt_reg;
    wfifo_rden      = '0;
    wr_en           = 1'b0;
    wr_data         = '0;
    wr_addr         = '0;
    burst_active    = 1'b0;
    burst_done      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rr_found) begin
          grant_next    = rr_pick;
          beat_cnt_next = '0;
          state_next    = BURST;
        end
      end
      BURST: begin
        burst_active          = 1'b1;
        wr_en                 = wr_ready;
        wfifo_rden[grant_reg] = wr_ready;
        wr_addr               = ch_addr[grant_reg];
        for (int c = 0; c < CH_NUM; c++) begin
          if (grant_reg == GW'(c)) wr_data = wfifo_dout[c*DATA_W +: DATA_W];
        end
        if (wr_ready) begin
          beat_cnt_next = beat_cnt_reg + BW'(1);
          if (beat_cnt_reg == BW'(BURST_LEN - 1)) state_next = DONE;
        end
      end
      DONE: begin
        burst_done      = 1'b1;
        last_grant_next = grant_reg;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_100) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= GW'(CH_NUM - 1);
      beat_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      beat_cnt_reg   <= beat_cnt_next;
    end
  end

  // A frame start landing mid-burst is deferred so the burst stays contiguous.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      for (int c = 0; c < CH_NUM; c++) ptr_reg[c] <= '0;
      pend_reg <= '0;
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (state_reg == DONE && grant_reg == GW'(c)) begin
          if (pend_reg[c] || frame_start[c]) ptr_reg[c] <= '0;
          pend_reg[c] <= 1'b0;
        end else if (state_reg == BURST && grant_reg == GW'(c)) begin
          if (frame_start[c]) pend_reg[c] <= 1'b1;
          if (wr_ready) begin
            ptr_reg[c] <= (ptr_reg[c] == PW'(FRAME_BEATS - 1)) ? '0 : ptr_reg[c] + PW'(1);
          end
        end else if (frame_start[c]) begin
          ptr_reg[c] <= '0;
        end
      end
    end
  end

  assign grant_ch = grant_reg;

endmodule
